// File: rtl/mmio_irq_timer_if.sv
// mmio_irq_timer_if
//   CPU data-memory load/store bus as seen by a memory-mapped peripheral.
//   Signals:
//     memwrite  - store strobe, qualified by dataadr
//     memread   - load strobe, qualified by dataadr
//     dataadr   - byte address
//     writedata - store data
//     readdata  - load data returned by the peripheral (registered there)
//   Handshake: memread/memwrite are single-cycle strobes with no back-pressure.
//   The peripheral is always ready; a store takes effect at the clock edge that
//   samples it, and load data is valid on readdata one cycle after the address.
//   Modports: master (CPU side), slave (peripheral side).
interface mmio_irq_timer_if;
  logic        memwrite;
  logic        memread;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output memwrite,
    output memread,
    output dataadr,
    output writedata,
    input  readdata
  );

  modport slave (
    input  memwrite,
    input  memread,
    input  dataadr,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/mmio_irq_timer.sv
// mmio_irq_timer
//   Memory-mapped compare-match timer and interrupt source for the MIPS core.
//   An 8-word register window at BASE_ADDR holds CTRL, COUNT, COMPARE, PENDING,
//   MASK and SWSET. A prescaled counter sets PENDING[TIMER_IRQ] on a compare
//   match; software can also set pending bits through SWSET. The registered
//   interrupts output is PENDING & MASK.
//
//   Ports:
//     ph1        - system clock, all state updates on posedge
//     reset      - synchronous, active-high reset
//     bus        - CPU load/store bus (slave modport of mmio_irq_timer_if)
//     interrupts - 8 active-high level interrupt lines, registered
//
//   Parameters:
//     BASE_ADDR - window base, 32-byte aligned
//     PRESCALE  - ph1 cycles per counter tick (1..65535)
//     TIMER_IRQ - pending bit set on a timer match (0..7)
//
//   Build option: define MMIO_IRQ_TIMER_ONESHOT_EN to make CTRL bit2 (ONESHOT)
//   writable; a match tick with ONESHOT set then clears EN. Without the macro
//   CTRL bit2 is not stored and reads 0.
module mmio_irq_timer #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
  parameter int unsigned PRESCALE  = 1,
  parameter int unsigned TIMER_IRQ = 0
) (
  input  logic                 ph1,
  input  logic                 reset,
  mmio_irq_timer_if.slave      bus,
  output logic [7:0]           interrupts
);

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);
  localparam logic [2:0]  TIMER_BIT  = 3'(TIMER_IRQ);

`ifdef MMIO_IRQ_TIMER_ONESHOT_EN
  localparam logic [2:0]  CTRL_WMASK = 3'b111;
`else
  localparam logic [2:0]  CTRL_WMASK = 3'b011;
`endif

  // Register select (word offset inside the window)
  localparam logic [2:0] SEL_CTRL    = 3'd0;
  localparam logic [2:0] SEL_COUNT   = 3'd1;
  localparam logic [2:0] SEL_COMPARE = 3'd2;
  localparam logic [2:0] SEL_PENDING = 3'd3;
  localparam logic [2:0] SEL_MASK    = 3'd4;
  localparam logic [2:0] SEL_SWSET   = 3'd5;

  // State
  logic [2:0]  ctrl_q,     ctrl_d;      // {ONESHOT, AUTORELOAD, EN}
  logic [31:0] count_q,    count_d;
  logic [31:0] compare_q,  compare_d;
  logic [7:0]  pending_q,  pending_d;
  logic [7:0]  mask_q,     mask_d;
  logic [15:0] presc_q,    presc_d;
  logic [31:0] readdata_q, readdata_d;
  logic [7:0]  irq_q,      irq_d;

  // Decode
  logic       hit;
  logic [2:0] sel;
  logic       wr_ctrl, wr_count, wr_compare, wr_pending, wr_mask, wr_swset;
  logic       rd_en;

  // Timer events
  logic tick;
  logic match;
  logic hw_set;
  logic oneshot_fire;

  // Byte lane bits of the address are ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.dataadr[1:0];

  always_comb begin
    hit        = (bus.dataadr[31:5] == BASE_ADDR[31:5]);
    sel        = bus.dataadr[4:2];
    rd_en      = bus.memread && hit;
    wr_ctrl    = bus.memwrite && hit && (sel == SEL_CTRL);
    wr_count   = bus.memwrite && hit && (sel == SEL_COUNT);
    wr_compare = bus.memwrite && hit && (sel == SEL_COMPARE);
    wr_pending = bus.memwrite && hit && (sel == SEL_PENDING);
    wr_mask    = bus.memwrite && hit && (sel == SEL_MASK);
    wr_swset   = bus.memwrite && hit && (sel == SEL_SWSET);
  end

  // Tick and match always look at the registered CTRL/COUNT, so a CPU write
  // in the same cycle only becomes visible to the timer on the next cycle.
  always_comb begin
    tick   = ctrl_q[0] && (presc_q == PRESC_LAST);
    match  = (count_q == compare_q);
    hw_set = tick && match;
`ifdef MMIO_IRQ_TIMER_ONESHOT_EN
    oneshot_fire = hw_set && ctrl_q[2];
`else
    oneshot_fire = 1'b0;
`endif
  end

  // Prescaler: held at 0 while disabled, wraps to 0 on each tick.
  always_comb begin
    presc_d = presc_q + 16'd1;
    if (!ctrl_q[0] || tick) begin
      presc_d = 16'd0;
    end
  end

  // Counter: a CPU write overrides the tick update.
  always_comb begin
    count_d = count_q;
    if (tick) begin
      if (match && ctrl_q[1]) begin
        count_d = 32'd0;
      end else begin
        count_d = count_q + 32'd1;
      end
    end
    if (wr_count) begin
      count_d = bus.writedata;
    end
  end

  // Control: a one-shot match clears EN even if the CPU writes CTRL that cycle.
  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_ctrl) begin
      ctrl_d = bus.writedata[2:0] & CTRL_WMASK;
    end
    if (oneshot_fire) begin
      ctrl_d[0] = 1'b0;
    end
  end

  always_comb begin
    compare_d = wr_compare ? bus.writedata : compare_q;
    mask_d    = wr_mask ? bus.writedata[7:0] : mask_q;
  end

  // Pending: W1C, then software set, then hardware set; the hardware set is
  // applied last so it survives a same-cycle clear of the timer bit.
  always_comb begin
    pending_d = pending_q;
    if (wr_pending) begin
      pending_d = pending_d & ~bus.writedata[7:0];
    end
    if (wr_swset) begin
      pending_d = pending_d | bus.writedata[7:0];
    end
    if (hw_set) begin
      pending_d[TIMER_BIT] = 1'b1;
    end
  end

  // Outputs are built from the current registers, so a same-cycle store is
  // not visible to a same-cycle load.
  always_comb begin
    irq_d      = pending_q & mask_q;
    readdata_d = readdata_q;
    if (rd_en) begin
      case (sel)
        SEL_CTRL:    readdata_d = {29'd0, ctrl_q};
        SEL_COUNT:   readdata_d = count_q;
        SEL_COMPARE: readdata_d = compare_q;
        SEL_PENDING: readdata_d = {24'd0, pending_q};
        SEL_MASK:    readdata_d = {24'd0, mask_q};
        default:     readdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge ph1) begin
    if (reset) begin
      ctrl_q     <= 3'd0;
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      pending_q  <= 8'd0;
      mask_q     <= 8'd0;
      presc_q    <= 16'd0;
      readdata_q <= 32'd0;
      irq_q      <= 8'd0;
    end else begin
      ctrl_q     <= ctrl_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      presc_q    <= presc_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign interrupts   = irq_q;

endmodule

// File: tb/tb_mmio_irq_timer.sv
// tb_mmio_irq_timer
//   Bench for mmio_irq_timer. Two instances share one CPU bus: u_dut1 with
//   PRESCALE=1/TIMER_IRQ=0 and u_dut2 with PRESCALE=3/TIMER_IRQ=5. A cycle
//   model of the register map predicts both each cycle; a vector table and
//   hand-written sequences check the documented corner cases explicitly.
module tb_mmio_irq_timer;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  localparam logic [7:0] OFF_CTRL    = 8'h00;
  localparam logic [7:0] OFF_COUNT   = 8'h04;
  localparam logic [7:0] OFF_COMPARE = 8'h08;
  localparam logic [7:0] OFF_PENDING = 8'h0C;
  localparam logic [7:0] OFF_MASK    = 8'h10;
  localparam logic [7:0] OFF_SWSET   = 8'h14;

`ifdef MMIO_IRQ_TIMER_ONESHOT_EN
  localparam logic [31:0] CTRL_MASK = 32'h7;
`else
  localparam logic [31:0] CTRL_MASK = 32'h3;
`endif

  // ---------------- clock / reset ----------------
  logic       ph1;
  logic       reset;
  logic [7:0] irq1, irq2;

  mmio_irq_timer_if bus1 ();
  mmio_irq_timer_if bus2 ();

  assign bus2.memwrite  = bus1.memwrite;
  assign bus2.memread   = bus1.memread;
  assign bus2.dataadr   = bus1.dataadr;
  assign bus2.writedata = bus1.writedata;

  mmio_irq_timer #(.BASE_ADDR(BASE), .PRESCALE(1), .TIMER_IRQ(0)) u_dut1 (
    .ph1        (ph1),
    .reset      (reset),
    .bus        (bus1.slave),
    .interrupts (irq1)
  );

  mmio_irq_timer #(.BASE_ADDR(BASE), .PRESCALE(3), .TIMER_IRQ(5)) u_dut2 (
    .ph1        (ph1),
    .reset      (reset),
    .bus        (bus2.slave),
    .interrupts (irq2)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] ctrl;
    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] rd;
    logic [7:0]  pending;
    logic [7:0]  mask;
    logic [7:0]  irq;
    logic [15:0] presc;
  } ms_t;

  ms_t m1, m2;

  function automatic logic [31:0] model_read(ms_t s, int sel);
    case (sel)
      0: return s.ctrl;
      1: return s.count;
      2: return s.compare;
      3: return {24'd0, s.pending};
      4: return {24'd0, s.mask};
      default: return 32'd0;
    endcase
  endfunction

  function automatic ms_t model_step(ms_t s, bit rst, bit we, bit re,
                                     logic [31:0] adr, logic [31:0] wd,
                                     int prescale, int tirq);
    ms_t n;
    bit  hit, tick, fire;
    int  sel;
    logic [31:0] base_v;
    if (rst) return '0;
    n      = s;
    base_v = BASE;
    hit    = (adr[31:5] == base_v[31:5]);
    sel    = int'(adr[4:2]);
    tick   = 1'b0;
    if (s.ctrl[0]) begin
      if (int'(s.presc) + 1 == prescale) begin
        tick    = 1'b1;
        n.presc = 16'd0;
      end else begin
        n.presc = s.presc + 16'd1;
      end
    end else begin
      n.presc = 16'd0;
    end
    n.irq = s.pending & s.mask;
    if (re && hit) n.rd = model_read(s, sel);
    fire = tick && (s.count == s.compare);
    if (tick) n.count = (fire && s.ctrl[1]) ? 32'd0 : s.count + 32'd1;
    if (we && hit) begin
      case (sel)
        0: n.ctrl    = wd & CTRL_MASK;
        1: n.count   = wd;
        2: n.compare = wd;
        3: n.pending = s.pending & ~wd[7:0];
        4: n.mask    = wd[7:0];
        5: n.pending = s.pending | wd[7:0];
        default: ;
      endcase
    end
    if (fire) n.pending[tirq] = 1'b1;
    if (fire && s.ctrl[2]) n.ctrl[0] = 1'b0;
    return n;
  endfunction

  // ---------------- driver ----------------
  // One bus cycle: drive, advance the model, clock, then check #1 later.
  task automatic cyc(input bit rst, input bit we, input bit re,
                     input logic [31:0] adr, input logic [31:0] wd);
    ms_t n1, n2;
    reset          = rst;
    bus1.memwrite  = we;
    bus1.memread   = re;
    bus1.dataadr   = adr;
    bus1.writedata = wd;
    n1 = model_step(m1, rst, we, re, adr, wd, 1, 0);
    n2 = model_step(m2, rst, we, re, adr, wd, 3, 5);
    @(posedge ph1);
    #1;
    m1 = n1;
    m2 = n2;
    chk("model_rd1",  bus1.readdata, m1.rd);
    chk("model_irq1", {24'd0, irq1}, {24'd0, m1.irq});
    chk("model_rd2",  bus2.readdata, m2.rd);
    chk("model_irq2", {24'd0, irq2}, {24'd0, m2.irq});
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    cyc(1'b0, 1'b1, 1'b0, BASE + 32'(off), d);
  endtask

  task automatic rd(input logic [7:0] off);
    cyc(1'b0, 1'b0, 1'b1, BASE + 32'(off), 32'd0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          we;
    bit          re;
    logic [7:0]  off;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [7:0]  exp_irq;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit we, input bit re, input logic [7:0] off,
                     input logic [31:0] wd, input logic [31:0] erd, input logic [7:0] eirq);
    vec_t v;
    v.we = we; v.re = re; v.off = off; v.wd = wd; v.exp_rd = erd; v.exp_irq = eirq;
    tbl.push_back(v);
  endtask

  // ---------------- test ----------------
  initial begin
    m1 = '0;
    m2 = '0;
    reset = 1'b1;
    bus1.memwrite = 1'b0; bus1.memread = 1'b0;
    bus1.dataadr = 32'd0; bus1.writedata = 32'd0;

    // window/load, reserved, SWSET/mask, W1C, same-cycle read/write, byte offsets
    add(1, 0, OFF_MASK,    32'h1FF,      32'h0,  8'h00);
    add(0, 1, OFF_MASK,    32'h0,        32'hFF, 8'h00);
    add(1, 0, 8'h20,       32'hFFFFFFFF, 32'hFF, 8'h00);
    add(0, 1, OFF_CTRL,    32'h0,        32'h0,  8'h00);
    add(0, 1, OFF_COUNT,   32'h0,        32'h0,  8'h00);
    add(0, 1, OFF_COMPARE, 32'h0,        32'h0,  8'h00);
    add(0, 1, OFF_PENDING, 32'h0,        32'h0,  8'h00);
    add(0, 1, OFF_MASK,    32'h0,        32'hFF, 8'h00);
    add(1, 0, 8'h18,       32'hFFFFFFFF, 32'hFF, 8'h00);
    add(0, 1, 8'h18,       32'h0,        32'h0,  8'h00);
    add(0, 1, 8'h1C,       32'h0,        32'h0,  8'h00);
    add(1, 0, OFF_MASK,    32'h0C,       32'h0,  8'h00);
    add(0, 1, OFF_SWSET,   32'h0,        32'h0,  8'h00);
    add(1, 0, OFF_SWSET,   32'h0E,       32'h0,  8'h00);
    add(0, 1, OFF_PENDING, 32'h0,        32'h0E, 8'h0C);
    add(1, 0, OFF_PENDING, 32'h04,       32'h0E, 8'h0C);
    add(0, 0, 8'h00,       32'h0,        32'h0E, 8'h08);
    add(0, 1, OFF_PENDING, 32'h0,        32'h0A, 8'h08);
    add(1, 0, OFF_PENDING, 32'hFF,       32'h0A, 8'h08);
    add(0, 0, 8'h00,       32'h0,        32'h0A, 8'h00);
    add(0, 1, OFF_PENDING, 32'h0,        32'h0,  8'h00);
    add(1, 1, OFF_MASK,    32'h55,       32'h0C, 8'h00);
    add(0, 1, OFF_MASK,    32'h0,        32'h55, 8'h00);
    add(1, 0, 8'h12,       32'h33,       32'h55, 8'h00);
    add(0, 1, 8'h11,       32'h0,        32'h33, 8'h00);

    cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("reset_readdata",   bus1.readdata, 32'd0);
    chk("reset_interrupts", {24'd0, irq1}, 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      exp_q.push_back(tbl[i].exp_rd);
      cyc(1'b0, tbl[i].we, tbl[i].re, BASE + 32'(tbl[i].off), tbl[i].wd);
      chk($sformatf("tbl%0d_rd", i), bus1.readdata, exp_q.pop_front());
      chk($sformatf("tbl%0d_irq", i), {24'd0, irq1}, {24'd0, tbl[i].exp_irq});
    end

    // timer match with autoreload, W1C timing, W1C colliding with a match
    wr(OFF_COMPARE, 32'd5);
    wr(OFF_MASK, 32'h01);
    wr(OFF_CTRL, 32'h3);
    repeat (5) idle();
    rd(OFF_PENDING);
    chk("match_not_before_6th_tick", bus1.readdata, 32'd0);
    chk("irq_not_yet", {24'd0, irq1}, 32'd0);
    rd(OFF_COUNT);
    chk("count_reloaded", bus1.readdata, 32'd0);
    chk("irq_after_match", {24'd0, irq1}, 32'd1);
    wr(OFF_PENDING, 32'h01);
    chk("irq_still_high_w1c_cycle", {24'd0, irq1}, 32'd1);
    idle();
    chk("irq_low_after_w1c", {24'd0, irq1}, 32'd0);
    idle();
    idle();
    wr(OFF_PENDING, 32'h01);
    rd(OFF_PENDING);
    chk("hw_set_beats_w1c", bus1.readdata, 32'd1);
    chk("hw_set_beats_w1c_irq", {24'd0, irq1}, 32'd1);
    wr(OFF_CTRL, 32'h0);
    idle();
    rd(OFF_COUNT);
    chk("count_frozen_when_disabled", bus1.readdata, 32'd2);
    wr(OFF_PENDING, 32'hFF);

    // 32-bit wrap and COUNT write priority
    wr(OFF_COMPARE, 32'd3);
    wr(OFF_COUNT, 32'hFFFF_FFFF);
    wr(OFF_CTRL, 32'h1);
    wr(OFF_CTRL, 32'h0);
    rd(OFF_COUNT);
    chk("count_wrap", bus1.readdata, 32'd0);
    rd(OFF_PENDING);
    chk("wrap_no_pending", bus1.readdata, 32'd0);
    wr(OFF_CTRL, 32'h1);
    wr(OFF_COUNT, 32'd100);
    rd(OFF_COUNT);
    chk("count_write_beats_tick", bus1.readdata, 32'd100);
    wr(OFF_CTRL, 32'h0);
    rd(OFF_COUNT);
    chk("count_ticks_after_write", bus1.readdata, 32'd102);

    // reset mid-operation
    wr(OFF_COUNT, 32'd7);
    wr(OFF_MASK, 32'h01);
    wr(OFF_SWSET, 32'h01);
    idle();
    rd(OFF_COUNT);
    chk("pre_reset_count", bus1.readdata, 32'd7);
    chk("pre_reset_irq", {24'd0, irq1}, 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("reset_clears_readdata", bus1.readdata, 32'd0);
    chk("reset_clears_irq", {24'd0, irq1}, 32'd0);
    for (int r = 0; r < 5; r++) begin
      rd(8'(r * 4));
      chk($sformatf("post_reset_reg%0d", r), bus1.readdata, 32'd0);
    end

`ifdef MMIO_IRQ_TIMER_ONESHOT_EN
    wr(OFF_COMPARE, 32'd2);
    wr(OFF_CTRL, 32'h5);
    repeat (6) idle();
    rd(OFF_COUNT);
    chk("oneshot_count_stops", bus1.readdata, 32'd3);
    rd(OFF_CTRL);
    chk("oneshot_en_cleared", bus1.readdata, 32'h4);
    rd(OFF_PENDING);
    chk("oneshot_pending", bus1.readdata, 32'h1);
`else
    wr(OFF_CTRL, 32'h4);
    rd(OFF_CTRL);
    chk("ctrl_bit2_not_stored", bus1.readdata, 32'h0);
`endif
    wr(OFF_CTRL, 32'h0);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      bit          rst_r, we_r, re_r;
      int          pick;
      logic [31:0] adr_r, wd_r;
      rst_r = ($urandom_range(0, 299) == 0);
      we_r  = ($urandom_range(0, 2) == 0);
      re_r  = ($urandom_range(0, 2) == 0);
      pick  = $urandom_range(0, 9);
      if (pick < 8)       adr_r = BASE + 32'(pick * 4) + 32'($urandom_range(0, 3));
      else if (pick == 8) adr_r = BASE + 32'h20 + 32'($urandom_range(0, 31));
      else                adr_r = $urandom;
      case (pick)
        0:       wd_r = 32'($urandom_range(0, 7));
        1, 2:    wd_r = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3))
                                                    : 32'($urandom_range(0, 15));
        default: wd_r = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
      endcase
      cyc(rst_r, we_r, re_r, adr_r, wd_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
